// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter feeding a single one-word output register.
//   Fixed priority (MODE=0) or round-robin (MODE=1) selection of one
//   requesting channel per cycle, with full-throughput valid/ready handshake.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - [N] per-channel request
//   in_data    - [N*WIDTH] channel i on bits [i*WIDTH +: WIDTH]
//   in_ready   - [N] combinational one-hot grant (zero when not accepting)
//   out_valid  - output register holds a valid word
//   out_data   - [WIDTH] registered selected word
//   out_sel    - [SELW] index of the channel that supplied out_data
//   out_ready  - downstream accept
module arb_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N-1:0]                          in_valid,
  input  logic [N*WIDTH-1:0]                    in_data,
  output logic [N-1:0]                          in_ready,
  output logic                                  out_valid,
  output logic [WIDTH-1:0]                      out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  out_sel,
  input  logic                                  out_ready
);

  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;

  logic             w_accept;
  logic             w_any;
  logic [SELW-1:0]  w_gidx;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_next;

  // Register can take a word when empty or when its word leaves this cycle.
  assign w_accept = !r_out_valid || out_ready;

  // Search starts at r_ptr (always 0 in fixed-priority mode) and wraps at N,
  // so indices >= N are never considered.
  always_comb begin
    int unsigned idx;
    w_any  = 1'b0;
    w_gidx = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(r_ptr) + k) % N;
      if (!w_any && in_valid[idx]) begin
        w_any  = 1'b1;
        w_gidx = SELW'(idx);
      end
    end
  end

  // rst_n gates the grant so nothing is accepted during a reset cycle.
  assign w_xfer   = rst_n && w_accept && w_any;
  assign in_ready = w_xfer ? (N'(1) << w_gidx) : '0;

  // Pointer moves just past the granted channel, wrapping from N-1 to 0.
  always_comb begin
    w_ptr_next = r_ptr;
    if (MODE == 1 && w_xfer) begin
      if (w_gidx == SELW'(N - 1)) begin
        w_ptr_next = '0;
      end else begin
        w_ptr_next = w_gidx + SELW'(1);
      end
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[32'(w_gidx)*WIDTH +: WIDTH];
        r_out_sel   <= w_gidx;
      end else if (out_ready) begin
        // Word drained with nothing to replace it; data/sel keep last values.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed bench for arb_mux with three instances:
//   u0: N=4 fixed priority, u1: N=4 round-robin, u2: N=3 round-robin.
// Inputs are changed 1 time unit after a rising edge; combinational in_ready
// is sampled 1 unit later, registered outputs 1 unit after the next edge.
module tb_arb_mux;

  logic clk;
  logic rst_n;

  logic [3:0]  v0, rdy0;
  logic [31:0] d0;
  logic        r0, ov0;
  logic [7:0]  od0;
  logic [1:0]  os0;

  logic [3:0]  v1, rdy1;
  logic [31:0] d1;
  logic        r1, ov1;
  logic [7:0]  od1;
  logic [1:0]  os1;

  logic [2:0]  v2, rdy2;
  logic [23:0] d2;
  logic        r2, ov2;
  logic [7:0]  od2;
  logic [1:0]  os2;

  int n_tests;
  int n_fail;

  arb_mux #(.WIDTH(8), .N(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(r0)
  );

  arb_mux #(.WIDTH(8), .N(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(r1)
  );

  arb_mux #(.WIDTH(8), .N(3), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(r2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    v0 = '1; v1 = '1; v2 = '1;
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    d0 = {8'h33, 8'h00, 8'h11, 8'h00};
    d1 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    d2 = {8'hB2, 8'hB1, 8'hB0};

    // Reset: no grants while rst_n is low, registers cleared afterwards
    #3;
    chk("rst_rdy0", 32'(rdy0), 32'h0);
    chk("rst_rdy1", 32'(rdy1), 32'h0);
    chk("rst_rdy2", 32'(rdy2), 32'h0);
    edge_wait();
    chk("rst_ov0", 32'(ov0), 32'h0);
    chk("rst_od0", 32'(od0), 32'h0);
    chk("rst_os0", 32'(os0), 32'h0);
    chk("rst_ov1", 32'(ov1), 32'h0);
    rst_n = 1'b1;
    v0 = '0; v1 = '0; v2 = '0;

    // Fixed priority: channels 1 and 3 requesting, channel 1 always wins
    v0 = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("fp_rdy", 32'(rdy0), 32'h2);
      edge_wait();
      chk("fp_ov", 32'(ov0), 32'h1);
      chk("fp_od", 32'(od0), 32'h11);
      chk("fp_os", 32'(os0), 32'h1);
    end
    // Drain with no new input: valid drops, data/sel hold
    v0 = 4'b0000;
    #1;
    chk("drain_rdy", 32'(rdy0), 32'h0);
    edge_wait();
    chk("drain_ov", 32'(ov0), 32'h0);
    chk("drain_od", 32'(od0), 32'h11);
    chk("drain_os", 32'(os0), 32'h1);

    // Round-robin, all requesting: grants 0,1,2,3,0 with back-to-back output
    v1 = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_rdy", 32'(rdy1), 32'(4'b0001 << (c % 4)));
      edge_wait();
      chk("rr_ov", 32'(ov1), 32'h1);
      chk("rr_os", 32'(os1), 32'(c % 4));
      chk("rr_od", 32'(od1), 32'(8'hC0 + c % 4));
    end
    // ptr=1: grant 2 moves ptr to 3, then only ch0 requests -> wrap grant
    v1 = 4'b0100;
    #1;
    chk("rr_g2_rdy", 32'(rdy1), 32'h4);
    edge_wait();
    chk("rr_g2_os", 32'(os1), 32'h2);
    v1 = 4'b0001;
    #1;
    chk("wrap_rdy", 32'(rdy1), 32'h1);
    edge_wait();
    chk("wrap_os", 32'(os1), 32'h0);
    chk("wrap_od", 32'(od1), 32'hC0);
    // ptr should now be 1
    v1 = 4'b1111;
    #1;
    chk("wrap_ptr_rdy", 32'(rdy1), 32'h2);
    edge_wait();
    chk("wrap_ptr_os", 32'(os1), 32'h1);

    // Backpressure: load A5 from ch2 (ptr 2 -> 3), then stall 3 cycles
    d1 = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
    v1 = 4'b0100;
    #1;
    chk("bp_load_rdy", 32'(rdy1), 32'h4);
    edge_wait();
    chk("bp_load_od", 32'(od1), 32'hA5);
    r1 = 1'b0;
    v1 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rdy", 32'(rdy1), 32'h0);
      edge_wait();
      chk("bp_ov", 32'(ov1), 32'h1);
      chk("bp_od", 32'(od1), 32'hA5);
      chk("bp_os", 32'(os1), 32'h2);
    end
    // Release: ptr still 3, so ch3 is granted and loaded in the same cycle
    r1 = 1'b1;
    #1;
    chk("rel_rdy", 32'(rdy1), 32'h8);
    edge_wait();
    chk("rel_ov", 32'(ov1), 32'h1);
    chk("rel_od", 32'(od1), 32'hC3);
    chk("rel_os", 32'(os1), 32'h3);

    // Mid-operation reset: u0 holds 5A from ch2, u1 ptr moved to 1
    d0 = {8'h33, 8'h5A, 8'h11, 8'h00};
    v0 = 4'b0100;
    v1 = 4'b0001;
    #1;
    chk("pre_rst_rdy0", 32'(rdy0), 32'h4);
    chk("pre_rst_rdy1", 32'(rdy1), 32'h1);
    edge_wait();
    chk("pre_rst_od0", 32'(od0), 32'h5A);
    chk("pre_rst_os0", 32'(os0), 32'h2);
    rst_n = 1'b0;
    r0 = 1'b0;
    v0 = 4'b0000;
    v1 = 4'b1111;
    v2 = 3'b111;
    #1;
    chk("mrst_rdy0", 32'(rdy0), 32'h0);
    chk("mrst_rdy1", 32'(rdy1), 32'h0);
    chk("mrst_rdy2", 32'(rdy2), 32'h0);
    edge_wait();
    chk("mrst_ov0", 32'(ov0), 32'h0);
    chk("mrst_od0", 32'(od0), 32'h0);
    chk("mrst_os0", 32'(os0), 32'h0);
    chk("mrst_ov1", 32'(ov1), 32'h0);
    chk("mrst_os1", 32'(os1), 32'h0);
    // First cycle after reset: empty register accepts even with out_ready=0
    rst_n = 1'b1;
    v0 = 4'b0001;
    v2 = 3'b000;
    #1;
    chk("post_rst_rdy0", 32'(rdy0), 32'h1);
    chk("post_rst_ptr0", 32'(rdy1), 32'h1);
    edge_wait();
    chk("post_rst_ov0", 32'(ov0), 32'h1);
    chk("post_rst_os0", 32'(os0), 32'h0);
    chk("post_rst_os1", 32'(os1), 32'h0);
    v0 = 4'b0000;
    v1 = 4'b0000;
    r0 = 1'b1;

    // N=3 round-robin: grants 0,1,2,0, never index 3
    v2 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("n3_rdy", 32'(rdy2), 32'(3'b001 << (c % 3)));
      edge_wait();
      chk("n3_ov", 32'(ov2), 32'h1);
      chk("n3_os", 32'(os2), 32'(c % 3));
      chk("n3_od", 32'(od2), 32'(8'hB0 + c % 3));
    end
    v2 = 3'b000;
    edge_wait();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port in_valid  input  N  per-channel request; bit i is channel i.
REQ-007 Port in_data  input  N*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready  output  N  per-channel accept; bit i high = channel i transfers this cycle.
REQ-009 Port out_valid  output  1  output register holds a valid word.
REQ-010 Port out_data  output  WIDTH  registered selected data.
REQ-011 Port out_sel  output  SELW = max(1, clog2(N))  index of the channel that supplied out_data.
REQ-012 Port out_ready  input  1  downstream accept.

Function
REQ-013 Input transfer on channel i SHALL occur in a cycle where in_valid[i] & in_ready[i] = 1; output transfer where out_valid & out_ready = 1.
REQ-014 accept = !out_valid | out_ready; in_ready SHALL be all-zero when accept = 0.
REQ-015 When accept = 1 and any in_valid set, exactly one in_ready bit (grant g) SHALL be 1; otherwise in_ready = 0.
REQ-016 in_ready SHALL be combinational from in_valid, out_valid, out_ready and the priority pointer only; it SHALL NOT depend on in_data.
REQ-017 MODE 0: g = lowest index i with in_valid[i] = 1.
REQ-018 MODE 1: g = first i with in_valid[i] = 1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-019 MODE 1: on each input transfer from g, ptr SHALL become (g+1) mod N next cycle; ptr SHALL be unchanged in cycles with no input transfer.
REQ-020 MODE 0: ptr SHALL stay 0.
REQ-021 On input transfer, next cycle out_valid = 1, out_data = in_data of g, out_sel = g (latency 1 cycle).
REQ-022 Output transfer with no input transfer in the same cycle SHALL clear out_valid next cycle; out_data/out_sel hold their last values.
REQ-023 Simultaneous output and input transfer SHALL reload the register with the new word; out_valid stays 1 (full throughput, one word per cycle).
REQ-024 While out_valid = 1 and out_ready = 0, out_valid, out_data and out_sel SHALL remain stable.
REQ-025 A channel dropping in_valid without transfer SHALL NOT alter ptr or output state.
REQ-026 N not a power of two: ptr wrap SHALL go from N-1 to 0; indices >= N never granted.

Reset
REQ-027 When rst_n = 0 at a rising edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0 from the next cycle.
REQ-028 During reset cycles in_ready SHALL be driven 0 regardless of inputs.
REQ-029 Reset asserted mid-operation SHALL discard any held word; no output transfer of it occurs after reset.
REQ-030 First cycle after rst_n returns to 1 SHALL behave as an empty register (accept = 1).

Verification
REQ-031 N=4, MODE=0, out_ready=1, in_valid=4'b1010, data ch1=8'h11 ch3=8'h33 for 2 cycles -> in_ready=4'b0010 both cycles; outputs 8'h11 sel=1 twice.
REQ-032 N=4, MODE=1, out_ready=1, in_valid=4'b1111 held 5 cycles -> grants 0,1,2,3,0; out_sel sequence 0,1,2,3,0 one cycle later.
REQ-033 MODE=1, ptr=3 after grant 2, in_valid=4'b0001 -> grant 0 via wrap; ptr becomes 1.
REQ-034 out_valid=1 out_data=8'hA5, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_data stays 8'hA5, ptr unchanged; out_ready=1 -> next word loaded same cycle.
REQ-035 rst_n=0 for 1 cycle while out_valid=1, out_data=8'h5A -> next cycle out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 during the reset cycle.
REQ-036 N=3, MODE=1, in_valid=3'b111 for 4 cycles -> grants 0,1,2,0 (no grant to index 3).
